pc_fetch_sequencer: RTL

//  Instruction-cycle controller for the CPU program counter. Sequences fetch -> execute -> PC update:
//  - issues instruction reads at the current PC and hands the instruction to the execute stage;
//  - waits for execute completion, then pulses the PC load strobe with a sequential or jump select;
//  - traps misaligned jump targets and instruction-fetch bus timeouts into a sticky fault state.

---
 rtl/pc_fetch_sequencer.sv | 84 ++++++++
 1 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: fetch -> execute -> PC-update controller with misaligned-jump and fetch-timeout traps
module pc_fetch_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_run,
    input  logic [31:0] i_pc,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_instr,
    output logic        o_instr_valid,
    input  logic        i_exec_done,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    output logic        o_load_PC,
    output logic        o_jump_DV,
    output logic [31:0] o_jump_address,
    output logic        o_fault,
    output logic [1:0]  o_fault_code,
    output logic [2:0]  o_state
);
    localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, EXEC = 3'd2, UPDATE = 3'd3, FAULT = 3'd4} state_t;
    state_t        state;
    logic [TW-1:0] timer;
    logic          taken_r;
    logic [31:0]   target_r;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            taken_r       <= 1'b0;
            target_r      <= '0;
            o_instr       <= '0;
            o_instr_valid <= 1'b0;
            o_fault_code  <= 2'b00;
        end else begin
            o_instr_valid <= 1'b0;
            case (state)
                IDLE: if (i_run) begin
                    state <= FETCH;
                    timer <= '0;
                end
                FETCH: if (i_mem_ack) begin
                    o_instr       <= i_mem_rdata;
                    o_instr_valid <= 1'b1;
                    timer         <= '0;
                    state         <= EXEC;
                end else if (TIMEOUT_CYCLES != 0 && timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    state        <= FAULT;
                    o_fault_code <= 2'b10;
                end else begin
                    timer <= timer + 1'b1;
                end
                EXEC: if (i_exec_done) begin
                    taken_r  <= i_branch_taken;
                    target_r <= i_branch_target;
                    if (i_branch_taken && i_branch_target[1:0] != 2'b00) begin
                        state        <= FAULT;
                        o_fault_code <= 2'b01;
                    end else begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    state <= i_run ? FETCH : IDLE;
                    timer <= '0;
                end
                default: state <= FAULT;
            endcase
        end
    end
    // Outputs decode straight from the state register so an async reset drops them at once.
    assign o_mem_req      = state == FETCH;
    assign o_mem_addr     = o_mem_req ? i_pc : 32'h0;
    assign o_load_PC      = state == UPDATE;
    assign o_jump_DV      = o_load_PC & taken_r;
    assign o_jump_address = o_load_PC ? target_r : 32'h0;
    assign o_fault        = state == FAULT;
    assign o_state        = state;
endmodule
